// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receive controller: FSM states,
// default counter width and byte positions inside the 32-bit NEC frame.
package ir_pkg;

    localparam int CNT_W     = 18;

    localparam int ADDR_LSB  = 0;
    localparam int NADDR_LSB = 8;
    localparam int CMD_LSB   = 16;
    localparam int NCMD_LSB  = 24;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP
    } ir_state_e;

endpackage

// File: rtl/ir_glitch_filter.sv
// Synchronizes the raw IR pin, maps it to a mark level and suppresses pulses
// shorter than rf_niose_th+1 cycles; emits the filtered level and edge pulses.
module ir_glitch_filter #(
    parameter int SYNC_STG = 2
) (
    input  logic       pclk,
    input  logic       prstn,
    input  logic       ir_in,
    input  logic       rf_ir_phase,
    input  logic [7:0] rf_niose_th,
    output logic       mark,
    output logic       mark_rise,
    output logic       mark_fall
);

    logic [SYNC_STG-1:0] sync_q;
    logic [7:0]          stab_cnt;
    logic                raw_mark;

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], ir_in};
        end
    end

    assign raw_mark = rf_ir_phase ? ~sync_q[SYNC_STG-1] : sync_q[SYNC_STG-1];

    // The edge pulses are registered together with the level so that both
    // describe the same filtered transition in the same cycle.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            mark      <= 1'b0;
            stab_cnt  <= '0;
            mark_rise <= 1'b0;
            mark_fall <= 1'b0;
        end else begin
            mark_rise <= 1'b0;
            mark_fall <= 1'b0;
            if (raw_mark != mark) begin
                if (stab_cnt == rf_niose_th) begin
                    mark      <= raw_mark;
                    stab_cnt  <= '0;
                    mark_rise <= raw_mark;
                    mark_fall <= ~raw_mark;
                end else begin
                    stab_cnt <= stab_cnt + 8'd1;
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ir_nec_rx_ctrl.sv
// NEC IR frame decoder: measures filtered mark/space widths, walks the frame
// FSM and maintains the sticky status and last-frame data for the APB block.
module ir_nec_rx_ctrl #(
    parameter int CNT_W    = 18,
    parameter int SYNC_STG = 2
) (
    input  logic             pclk,
    input  logic             prstn,
    input  logic             ir_in,
    input  logic             rf_ir_phase,
    input  logic [7:0]       rf_niose_th,
    input  logic [12:0]      rf_edge_th,
    input  logic [CNT_W-1:0] rf_9ms_cnt,
    input  logic [CNT_W-1:0] rf_4p5_cnt,
    input  logic [CNT_W-1:0] rf_1p69_cnt,
    input  logic [CNT_W-1:0] rf_2p25_cnt,
    input  logic             rf_addr_cmp_en,
    input  logic             rf_data_cmp_en,
    input  logic             rf_int_clr,
    input  logic             rf_cmp_clr,
    output logic [31:0]      ir_data,
    output logic             ir_int,
    output logic             ir_repeat,
    output logic             ir_cmp_err
);

    import ir_pkg::*;

    localparam int CW1 = CNT_W + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // |meas - nom| <= tol with one extra bit so the difference never wraps.
    function automatic logic within_tol(input logic [CNT_W-1:0] meas,
                                        input logic [CNT_W-1:0] nom,
                                        input logic [12:0]      tol);
        logic signed [CNT_W:0] diff;
        logic        [CNT_W:0] mag;
        diff = $signed({1'b0, meas}) - $signed({1'b0, nom});
        mag  = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
        return mag <= CW1'(tol);
    endfunction

    logic             mark;
    logic             mark_rise;
    logic             mark_fall;
    logic [CNT_W-1:0] cnt;
    ir_state_e        state, state_nxt;
    logic [31:0]      shift_q, shift_nxt;
    logic [4:0]       bitcnt, bitcnt_nxt;
    logic [31:0]      data_nxt;
    logic             int_nxt, rep_nxt, err_nxt;
    logic [31:0]      frame_word;
    logic             cmp_fail;
    logic             hit_9ms, hit_4p5, hit_2p25, hit_1p69;
    logic             timeout;

    ir_glitch_filter #(
        .SYNC_STG (SYNC_STG)
    ) u_filter (
        .pclk        (pclk),
        .prstn       (prstn),
        .ir_in       (ir_in),
        .rf_ir_phase (rf_ir_phase),
        .rf_niose_th (rf_niose_th),
        .mark        (mark),
        .mark_rise   (mark_rise),
        .mark_fall   (mark_fall)
    );

    // Width counter holds the length of the interval that just ended while an
    // edge pulse is present.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            cnt <= '0;
        end else if (mark_rise || mark_fall) begin
            cnt <= '0;
        end else begin
            cnt <= sat_inc(cnt);
        end
    end

    assign hit_9ms  = within_tol(cnt, rf_9ms_cnt,  rf_edge_th);
    assign hit_4p5  = within_tol(cnt, rf_4p5_cnt,  rf_edge_th);
    assign hit_2p25 = within_tol(cnt, rf_2p25_cnt, rf_edge_th);
    assign hit_1p69 = within_tol(cnt, rf_1p69_cnt, rf_edge_th);
    assign timeout  = {1'b0, cnt} > ({1'b0, rf_9ms_cnt} + CW1'(rf_edge_th));

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state      <= IDLE;
            shift_q    <= '0;
            bitcnt     <= '0;
            ir_data    <= '0;
            ir_int     <= 1'b0;
            ir_repeat  <= 1'b0;
            ir_cmp_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bitcnt     <= bitcnt_nxt;
            ir_data    <= data_nxt;
            ir_int     <= int_nxt;
            ir_repeat  <= rep_nxt;
            ir_cmp_err <= err_nxt;
        end
    end

    // Clears are applied first so that any set further down overrides them.
    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift_q;
        bitcnt_nxt = bitcnt;
        data_nxt   = ir_data;
        int_nxt    = ir_int & ~rf_int_clr;
        rep_nxt    = ir_repeat & ~rf_int_clr;
        err_nxt    = ir_cmp_err & ~rf_cmp_clr;
        frame_word = {hit_1p69, shift_q[31:1]};
        cmp_fail   = (rf_addr_cmp_en &&
                      (frame_word[NADDR_LSB +: 8] != ~frame_word[ADDR_LSB +: 8])) ||
                     (rf_data_cmp_en &&
                      (frame_word[NCMD_LSB +: 8] != ~frame_word[CMD_LSB +: 8]));

        if (state != IDLE && timeout) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (mark_rise) state_nxt = LEAD_MARK;
                end
                LEAD_MARK: begin
                    if (mark_fall) state_nxt = hit_9ms ? LEAD_SPACE : IDLE;
                end
                LEAD_SPACE: begin
                    if (mark_rise) begin
                        if (hit_4p5) begin
                            state_nxt  = BIT_MARK;
                            bitcnt_nxt = '0;
                        end else if (hit_2p25) begin
                            state_nxt = STOP;
                            rep_nxt   = 1'b1;
                            int_nxt   = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                BIT_MARK: begin
                    if (mark_fall) state_nxt = (cnt < rf_1p69_cnt) ? BIT_SPACE : IDLE;
                end
                BIT_SPACE: begin
                    if (mark_rise) begin
                        if (hit_1p69 || (cnt < (rf_1p69_cnt >> 1))) begin
                            shift_nxt = frame_word;
                            if (bitcnt == 5'd31) begin
                                state_nxt = STOP;
                                data_nxt  = frame_word;
                                if (cmp_fail) begin
                                    err_nxt = 1'b1;
                                end else begin
                                    int_nxt = 1'b1;
                                    rep_nxt = 1'b0;
                                end
                            end else begin
                                state_nxt  = BIT_MARK;
                                bitcnt_nxt = bitcnt + 5'd1;
                            end
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                STOP: begin
                    if (!mark) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_nec_rx_ctrl.sv
// Scoreboard bench for ir_nec_rx_ctrl: directed NEC frames, repeat codes,
// glitches, timeouts and resets; a monitor compares every status update.
module tb_ir_nec_rx_ctrl;

    localparam int CNT_W = 18;

    logic             pclk = 1'b0;
    logic             prstn = 1'b0;
    logic             ir_drv = 1'b1;
    logic             glitch = 1'b0;
    logic             glitch_en = 1'b0;
    logic             ir_in;
    logic             rf_ir_phase = 1'b1;
    logic [7:0]       rf_niose_th = 8'd3;
    logic [12:0]      rf_edge_th = 13'd20;
    logic [CNT_W-1:0] rf_9ms_cnt = 18'd900;
    logic [CNT_W-1:0] rf_4p5_cnt = 18'd450;
    logic [CNT_W-1:0] rf_1p69_cnt = 18'd169;
    logic [CNT_W-1:0] rf_2p25_cnt = 18'd225;
    logic             rf_addr_cmp_en = 1'b0;
    logic             rf_data_cmp_en = 1'b0;
    logic             rf_int_clr = 1'b0;
    logic             rf_cmp_clr = 1'b0;
    logic [31:0]      ir_data;
    logic             ir_int;
    logic             ir_repeat;
    logic             ir_cmp_err;

    assign ir_in = ir_drv & ~glitch;

    always #5 pclk = ~pclk;

    ir_nec_rx_ctrl #(
        .CNT_W    (CNT_W),
        .SYNC_STG (2)
    ) dut (
        .pclk           (pclk),
        .prstn          (prstn),
        .ir_in          (ir_in),
        .rf_ir_phase    (rf_ir_phase),
        .rf_niose_th    (rf_niose_th),
        .rf_edge_th     (rf_edge_th),
        .rf_9ms_cnt     (rf_9ms_cnt),
        .rf_4p5_cnt     (rf_4p5_cnt),
        .rf_1p69_cnt    (rf_1p69_cnt),
        .rf_2p25_cnt    (rf_2p25_cnt),
        .rf_addr_cmp_en (rf_addr_cmp_en),
        .rf_data_cmp_en (rf_data_cmp_en),
        .rf_int_clr     (rf_int_clr),
        .rf_cmp_clr     (rf_cmp_clr),
        .ir_data        (ir_data),
        .ir_int         (ir_int),
        .ir_repeat      (ir_repeat),
        .ir_cmp_err     (ir_cmp_err)
    );

    // Observation word: {ir_data, ir_int, ir_repeat, ir_cmp_err}
    logic [34:0] exp_q[$];
    logic [34:0] prev_obs = '0;
    logic [34:0] cur_obs;
    logic [34:0] exp_obs;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          gcnt = 0;

    function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] na,
                                             input logic [7:0] c, input logic [7:0] nc);
        return {nc, c, na, a};
    endfunction

    task automatic chk(input string name, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got data=%h int=%b rep=%b err=%b, required data=%h int=%b rep=%b err=%b",
                     name, got[34:3], got[2], got[1], got[0], exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every change of the observed status is one DUT response.
    always @(negedge pclk) begin
        cur_obs = {ir_data, ir_int, ir_repeat, ir_cmp_err};
        if (mon_en && cur_obs !== prev_obs) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got data=%h int=%b rep=%b err=%b, required no change",
                         cur_obs[34:3], cur_obs[2], cur_obs[1], cur_obs[0]);
            end else begin
                exp_obs = exp_q.pop_front();
                chk("scoreboard", cur_obs, exp_obs);
            end
        end
        prev_obs = cur_obs;
    end

    // Two-cycle low pulses every 40 cycles while enabled.
    always @(negedge pclk) begin
        gcnt   = (gcnt + 1) % 40;
        glitch = glitch_en && (gcnt < 2);
    end

    task automatic hold(input logic lvl, input int n);
        ir_drv = lvl;
        repeat (n) @(negedge pclk);
    endtask

    // Mark is ir_in low (phase 1); bit space 169 = '1', 56 = '0', LSB first.
    task automatic send_frame(input logic [31:0] w, input int lead, input int nbits,
                              input bit stop, input bit clr_at_commit);
        hold(1'b0, lead);
        hold(1'b1, 450);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 56);
            hold(1'b1, w[i] ? 169 : 56);
        end
        if (stop) begin
            if (clr_at_commit) begin
                // Commit registers SYNC_STG + noise_th + 2 = 7 cycles after the
                // stop-mark edge; the clear is live during the cycle before it.
                ir_drv = 1'b0;
                repeat (6) @(negedge pclk);
                rf_int_clr = 1'b1;
                @(negedge pclk);
                rf_int_clr = 1'b0;
                repeat (49) @(negedge pclk);
            end else begin
                hold(1'b0, 56);
            end
        end
        hold(1'b1, 300);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge pclk);
        chk("reset_data",    {ir_data, 3'b000}, 35'd0);
        chk("reset_int",     {32'd0, ir_int, 2'b00}, 35'd0);
        chk("reset_repeat",  {32'd0, 1'b0, ir_repeat, 1'b0}, 35'd0);
        chk("reset_cmp_err", {32'd0, 2'b00, ir_cmp_err}, 35'd0);
        prstn  = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(negedge pclk);

        // Clean frame addr 0x5A, cmd 0x3C.
        exp_q.push_back({32'hC33CA55A, 3'b100});
        send_frame(nec_word(8'h5A, 8'hA5, 8'h3C, 8'hC3), 900, 32, 1'b1, 1'b0);

        // Repeat code keeps the data, sets repeat.
        exp_q.push_back({32'hC33CA55A, 3'b110});
        hold(1'b0, 900);
        hold(1'b1, 225);
        hold(1'b0, 56);
        hold(1'b1, 300);

        // Interrupt clear.
        exp_q.push_back({32'hC33CA55A, 3'b000});
        rf_int_clr = 1'b1;
        @(negedge pclk);
        rf_int_clr = 1'b0;
        chk("int_clr_next_cycle", {ir_data, ir_int, ir_repeat, ir_cmp_err}, {32'hC33CA55A, 3'b000});
        repeat (20) @(negedge pclk);

        // Command complement check fails.
        rf_data_cmp_en = 1'b1;
        exp_q.push_back({32'h003CA55A, 3'b001});
        send_frame(nec_word(8'h5A, 8'hA5, 8'h3C, 8'h00), 900, 32, 1'b1, 1'b0);

        exp_q.push_back({32'h003CA55A, 3'b000});
        rf_cmp_clr = 1'b1;
        @(negedge pclk);
        rf_cmp_clr = 1'b0;
        chk("cmp_clr_next_cycle", {ir_data, ir_int, ir_repeat, ir_cmp_err}, {32'h003CA55A, 3'b000});
        repeat (20) @(negedge pclk);

        // Short glitches are filtered out.
        exp_q.push_back({32'hC33CA55A, 3'b100});
        glitch_en = 1'b1;
        send_frame(nec_word(8'h5A, 8'hA5, 8'h3C, 8'hC3), 900, 32, 1'b1, 1'b0);
        glitch_en = 1'b0;

        // Lead mark out of tolerance: nothing decoded.
        send_frame(nec_word(8'h11, 8'hEE, 8'h22, 8'hDD), 850, 32, 1'b1, 1'b0);
        chk("lead_850_ignored", {ir_data, ir_int, ir_repeat, ir_cmp_err}, {32'hC33CA55A, 3'b100});

        // Truncated frame times out, then a full frame still decodes.
        send_frame(nec_word(8'h01, 8'hFE, 8'h80, 8'h7F), 900, 12, 1'b0, 1'b0);
        hold(1'b1, 1000);
        chk("timeout_no_status", {ir_data, ir_int, ir_repeat, ir_cmp_err}, {32'hC33CA55A, 3'b100});
        exp_q.push_back({32'h7F80FE01, 3'b100});
        send_frame(nec_word(8'h01, 8'hFE, 8'h80, 8'h7F), 900, 32, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a lead mark.
        exp_q.push_back(35'd0);
        ir_drv = 1'b0;
        repeat (300) @(negedge pclk);
        @(posedge pclk);
        #2 prstn = 1'b0;
        #1 chk("async_reset_immediate", {ir_data, ir_int, ir_repeat, ir_cmp_err}, 35'd0);
        @(negedge pclk);
        ir_drv = 1'b1;
        repeat (5) @(negedge pclk);
        prstn = 1'b1;
        repeat (20) @(negedge pclk);

        // Clear pulse in the commit cycle: the set wins.
        exp_q.push_back({32'hF00F5AA5, 3'b100});
        send_frame(nec_word(8'hA5, 8'h5A, 8'h0F, 8'hF0), 900, 32, 1'b1, 1'b1);
        chk("set_wins_over_clr", {ir_data, ir_int, ir_repeat, ir_cmp_err}, {32'hF00F5AA5, 3'b100});

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge pclk);
        while (exp_q.size() != 0) begin
            exp_obs = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_update: got no response, required data=%h int=%b rep=%b err=%b",
                     exp_obs[34:3], exp_obs[2], exp_obs[1], exp_obs[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_nec_rx_ctrl.md
Name: ir_nec_rx_ctrl

Overview:
NEC-protocol IR receive controller; sequences frame decode of the demodulated IR input using the timing/config fields of the IR APB register block (rf_*), and returns ir_data/ir_int/ir_repeat/ir_cmp_err status to it. Contains input synchronizer, glitch filter, pulse-width counter and frame FSM. Sits between IR pad and the APB register file, same pclk domain.

Parameters:
CNT_W, 18, pulse-width counter width (matches rf_*_cnt fields)
SYNC_STG, 2, synchronizer flops on ir_in

Ports:
pclk  in  1  clock
prstn  in  1  async reset, active low
ir_in  in  1  raw demodulated IR pin, asynchronous
rf_ir_phase  in  1  1: mark = ir_in low; 0: mark = ir_in high
rf_niose_th  in  8  glitch filter length, pclk cycles
rf_edge_th  in  13  timing tolerance ±, pclk cycles
rf_9ms_cnt/rf_4p5_cnt/rf_1p69_cnt/rf_2p25_cnt  in  18 each  nominal lead mark / lead space / bit-1 space / repeat space, pclk cycles
rf_addr_cmp_en  in  1  enable addr vs ~addr check
rf_data_cmp_en  in  1  enable cmd vs ~cmd check
rf_int_clr  in  1  one-cycle clear of ir_int and ir_repeat
rf_cmp_clr  in  1  one-cycle clear of ir_cmp_err
ir_data  out  32  last complete frame, LSB-first: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
ir_int  out  1  sticky: valid frame or repeat received
ir_repeat  out  1  sticky: last event was repeat code
ir_cmp_err  out  1  sticky: enabled complement check failed

Behaviour:
- Reset (async, prstn low): ir_data=0, ir_int=0, ir_repeat=0, ir_cmp_err=0, FSM=IDLE, counters 0, filter output = inactive (no mark), sync flops = idle level per rf_ir_phase reset (1 → high).
- Sync: SYNC_STG flops; mark = rf_ir_phase ? ~sync : sync.
- Filter: filtered level changes only after sync mark differs from it for rf_niose_th+1 consecutive cycles; th=0 → 1-cycle delay. Mark edges = edges of filtered level.
- cnt: reset to 0 on every filtered edge, else +1, saturates at all-ones. "match(x)" = |cnt − x| ≤ rf_edge_th, evaluated at the edge with 19-bit arithmetic, no wrap.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP.
  IDLE: mark start → LEAD_MARK.
  LEAD_MARK: mark end: match(9ms) → LEAD_SPACE, else IDLE.
  LEAD_SPACE: mark start: match(4p5) → BIT_MARK, bitcnt=0; match(2p25) → set ir_repeat, ir_int → STOP; else IDLE. 4p5 checked first.
  BIT_MARK: mark end: cnt < rf_1p69_cnt → BIT_SPACE, else IDLE.
  BIT_SPACE: mark start: match(1p69) → bit 1; cnt < rf_1p69_cnt>>1 → bit 0; else IDLE (discard). Bit shifted in at MSB of shift reg (LSB-first). bitcnt 31 → commit → STOP, else bitcnt+1 → BIT_MARK.
  STOP: mark end → IDLE.
- Commit: ir_data ← shift reg (always). err = (addr_cmp_en & [15:8]≠~[7:0]) | (data_cmp_en & [31:24]≠~[23:16]). err → ir_cmp_err=1, ir_int unchanged. No err → ir_int=1, ir_repeat=0.
- Timeout: any non-IDLE state with cnt > rf_9ms_cnt + rf_edge_th → IDLE, no status change, partial frame discarded.
- Set vs clear same cycle: set wins (ir_int, ir_repeat, ir_cmp_err).
- Latency: status/data update 1 cycle after filtered edge registered; total from ir_in edge = SYNC_STG + rf_niose_th + 2 cycles.
- rf_* changes mid-frame take effect immediately; no shadowing.
- Repeat with no prior frame: still sets ir_repeat/ir_int; ir_data unchanged.

Decomposition:
- Package ir_pkg: FSM state enum, CNT_W, NEC field offsets (ADDR_LSB=0, NADDR_LSB=8, CMD_LSB=16, NCMD_LSB=24).
- Sub-module ir_glitch_filter (sync + stability counter, outputs filtered mark and rise/fall pulses). Counter, FSM, status in top.

Test Plan:
- Timing cfg 9ms=900, 4p5=450, 2p25=225, 1p69=169, edge_th=20, noise_th=3, phase=1; send frame addr 0x5A, cmd 0x3C (mark 56, space 56/169) → ir_data=0xC33CA55A, ir_int=1, ir_repeat=0, ir_cmp_err=0.
- After above, lead 900 + space 225 + mark 56 → ir_repeat=1, ir_int=1, ir_data unchanged; pulse rf_int_clr → both 0 next cycle.
- data_cmp_en=1, frame ~cmd byte 0x00 with cmd 0x3C → ir_cmp_err=1, ir_int=0, ir_data=0x003CA55A; rf_cmp_clr pulse → ir_cmp_err=0.
- 2-cycle low glitches every 40 cycles during a valid frame (noise_th=3) → decodes identically; lead mark 850 (outside ±20) → stays IDLE, no status change.
- Stop input after 12 bits → timeout after >920 idle cycles, IDLE, no ir_int; next full frame decodes correctly. Assert prstn mid-frame → all outputs 0 immediately.
- rf_int_clr pulse coinciding with commit cycle → ir_int=1 (set wins).
